// File: rtl/left_normalizer_11.sv
// left_normalizer_11: post-add fp16 significand normalizer, one barrel stage (8,4,2,1) per clock.
// Optional FP_NORM_STICKY_EN adds out_sticky carrying the bit lost on the carry right-shift.
module left_normalizer_11 #(
  parameter int WIDTH = 11,
  parameter int EXP_W = 5,
  parameter int NSTG  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
`ifdef FP_NORM_STICKY_EN
  output logic             out_sticky,
`endif
  output logic             out_ovf
);
  localparam int KW = (NSTG > 1) ? $clog2(NSTG) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [KW-1:0]    k_q, k_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
`ifdef FP_NORM_STICKY_EN
  logic             sticky_q, sticky_d;
`endif
  logic             idle, hit, last, ovf_c;
  logic [EXP_W-1:0] e_in, st_e, nx_e;
  logic [EXP_W:0]   e_inc;
  logic [WIDTH-1:0] st_m, nx_m;
  logic [KW-1:0]    st_k;
  int               sh;
  // The accept edge already performs the widest stage so the shift path totals NSTG edges.
  always_comb begin
    idle  = state_q == S_IDLE;
    e_in  = (in_exp == '0) ? EXP_W'(1) : in_exp;
    e_inc = {1'b0, e_in} + 1'b1;
    ovf_c = e_inc >= {1'b0, {EXP_W{1'b1}}};
    st_m  = idle ? in_mant[WIDTH-1:0] : mant_q;
    st_e  = idle ? e_in : exp_q;
    st_k  = idle ? KW'(NSTG - 1) : k_q;
    sh    = 1 << st_k;
    hit   = ((st_m >> (WIDTH - sh)) == '0) && (int'(st_e) > sh);
    nx_m  = hit ? st_m << sh : st_m;
    nx_e  = hit ? st_e - EXP_W'(sh) : st_e;
    last  = st_k == '0;
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    k_d     = k_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`ifdef FP_NORM_STICKY_EN
    sticky_d = sticky_q;
`endif
    if (idle && in_valid) begin
      zero_d  = 1'b0;
      ovf_d   = 1'b0;
      state_d = S_DONE;
`ifdef FP_NORM_STICKY_EN
      sticky_d = in_mant[WIDTH] & in_mant[0];
`endif
      if (in_mant[WIDTH]) begin
        ovf_d  = ovf_c;
        mant_d = ovf_c ? '0 : in_mant[WIDTH:1];
        exp_d  = ovf_c ? '1 : e_inc[EXP_W-1:0];
      end else if (in_mant == '0) begin
        zero_d = 1'b1;
        mant_d = '0;
        exp_d  = '0;
      end else if (in_mant[WIDTH-1]) begin
        mant_d = in_mant[WIDTH-1:0];
        exp_d  = e_in;
      end else begin
        mant_d  = nx_m;
        exp_d   = (last && !nx_m[WIDTH-1]) ? '0 : nx_e;
        k_d     = st_k - 1'b1;
        state_d = last ? S_DONE : S_SHIFT;
      end
    end else if (state_q == S_SHIFT) begin
      mant_d  = nx_m;
      exp_d   = (last && !nx_m[WIDTH-1]) ? '0 : nx_e;
      k_d     = st_k - 1'b1;
      state_d = last ? S_DONE : S_SHIFT;
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      k_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef FP_NORM_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      k_q     <= k_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`ifdef FP_NORM_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
`ifdef FP_NORM_STICKY_EN
  assign out_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_left_normalizer_11.sv
// tb_left_normalizer_11: directed self-checking bench for left_normalizer_11.
module tb_left_normalizer_11;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_mant = '0;
  logic [4:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_mant;
  logic [4:0]  out_exp;
  logic        out_zero;
  logic        out_ovf;
`ifdef FP_NORM_STICKY_EN
  logic        out_sticky;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  left_normalizer_11 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero),
`ifdef FP_NORM_STICKY_EN
    .out_sticky(out_sticky),
`endif
    .out_ovf(out_ovf)
  );
  task automatic send(input logic [11:0] m, input logic [4:0] e);
    in_mant = m;
    in_exp = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    checks++; if (out_mant !== 11'h000 || out_exp !== 5'd0) begin errors++; $display("FAIL reset_data got=%h/%0d want=000/0", out_mant, out_exp); end
    checks++; if (out_zero !== 1'b0 || out_ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", out_zero, out_ovf); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_normal;
    send(12'h400, 5'd15);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL normal_valid got=%b want=1", out_valid); end
    checks++; if (out_mant !== 11'h400) begin errors++; $display("FAIL normal_mant got=%h want=400", out_mant); end
    checks++; if (out_exp !== 5'd15) begin errors++; $display("FAIL normal_exp got=%0d want=15", out_exp); end
    checks++; if (out_zero !== 1'b0 || out_ovf !== 1'b0) begin errors++; $display("FAIL normal_flags got=%b%b want=00", out_zero, out_ovf); end
    drain();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL normal_drain got=%b%b want=01", out_valid, in_ready); end
  endtask
  task automatic test_carry;
    send(12'hC01, 5'd15);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL carry_valid got=%b want=1", out_valid); end
    checks++; if (out_mant !== 11'h600 || out_exp !== 5'd16) begin errors++; $display("FAIL carry_data got=%h/%0d want=600/16", out_mant, out_exp); end
`ifdef FP_NORM_STICKY_EN
    checks++; if (out_sticky !== 1'b1) begin errors++; $display("FAIL carry_sticky got=%b want=1", out_sticky); end
`endif
    drain();
  endtask
  task automatic test_shift;
    send(12'h001, 5'd20);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL shift_early got=%b want=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL shift_valid got=%b want=1", out_valid); end
    checks++; if (out_mant !== 11'h400 || out_exp !== 5'd10) begin errors++; $display("FAIL shift_data got=%h/%0d want=400/10", out_mant, out_exp); end
    drain();
  endtask
  task automatic test_subnormal;
    send(12'h010, 5'd3);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL subn_valid got=%b want=1", out_valid); end
    checks++; if (out_mant !== 11'h040 || out_exp !== 5'd0) begin errors++; $display("FAIL subn_data got=%h/%0d want=040/0", out_mant, out_exp); end
    drain();
    send(12'h200, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_mant !== 11'h200 || out_exp !== 5'd0) begin errors++; $display("FAIL exp0_data got=%h/%0d want=200/0", out_mant, out_exp); end
    drain();
  endtask
  task automatic test_zero_ovf;
    send(12'h000, 5'd9);
    checks++; if (out_zero !== 1'b1 || out_ovf !== 1'b0 || out_exp !== 5'd0 || out_mant !== 11'h000) begin errors++; $display("FAIL zero_out got=z%b o%b %h/%0d want=z1 o0 000/0", out_zero, out_ovf, out_mant, out_exp); end
    drain();
    send(12'h800, 5'd30);
    checks++; if (out_ovf !== 1'b1 || out_zero !== 1'b0 || out_exp !== 5'h1F || out_mant !== 11'h000) begin errors++; $display("FAIL ovf_out got=z%b o%b %h/%0d want=z0 o1 000/31", out_zero, out_ovf, out_mant, out_exp); end
    drain();
  endtask
  task automatic test_stall;
    send(12'h400, 5'd15);
    in_mant = 12'h000;
    in_exp = 5'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hs%0d got=%b%b want=10", i, out_valid, in_ready); end
      checks++; if (out_mant !== 11'h400 || out_exp !== 5'd15 || out_zero !== 1'b0 || out_ovf !== 1'b0) begin errors++; $display("FAIL stall_data%0d got=%h/%0d/%b%b want=400/15/00", i, out_mant, out_exp, out_zero, out_ovf); end
`ifdef FP_NORM_STICKY_EN
      checks++; if (out_sticky !== 1'b0) begin errors++; $display("FAIL stall_sticky%0d got=%b want=0", i, out_sticky); end
`endif
    end
    in_valid = 1'b0;
    drain();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_drain got=%b%b want=01", out_valid, in_ready); end
  endtask
  task automatic test_reset_mid;
    send(12'h001, 5'd20);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_hs got=%b%b want=01", out_valid, in_ready); end
    checks++; if (out_mant !== 11'h000 || out_exp !== 5'd0) begin errors++; $display("FAIL midrst_data got=%h/%0d want=000/0", out_mant, out_exp); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b want=0", out_valid); end
    send(12'h004, 5'd20);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_mant !== 11'h400 || out_exp !== 5'd12) begin errors++; $display("FAIL midrst_next got=%b %h/%0d want=1 400/12", out_valid, out_mant, out_exp); end
    drain();
  endtask
  initial begin
    test_reset();
    test_normal();
    test_carry();
    test_shift();
    test_subnormal();
    test_zero_ovf();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
